// File: rtl/lsu_seq_if.sv
// lsu_seq_if: request/response handshake between the execute stage and the load/store sequencer
interface lsu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_memop;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_addr, req_memop, req_we, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_addr, req_memop, req_we, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer splitting misaligned accesses into little-endian byte beats
module lsu_seq #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  lsu_seq_if.slave    bus,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_datain,
  output logic [2:0]  dm_memop,
  output logic        dm_we,
  input  logic [31:0] dm_dataout
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;
  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_memop;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_mis;
  logic [2:0]  r_i;
  logic [2:0]  r_beats;
  logic [31:0] r_asm;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [2:0]  w_n;
  logic        w_mis;
  logic        w_err;
  logic        w_last;
  logic        w_act;
  logic [31:0] w_asm;
  logic [31:0] w_ext;
  // request decode, byte assembly and memory-side drive derived from the current state
  always_comb begin
    w_n = bus.req_memop[1] ? 3'd4 : bus.req_memop[0] ? 3'd2 : 3'd1;
    w_mis = (w_n == 3'd2 && bus.req_addr[0]) || (w_n == 3'd4 && bus.req_addr[1:0] != 2'b00);
    w_err = bus.req_memop == 3'b011 || (bus.req_memop[2] && (bus.req_memop[1] || bus.req_we)) || (w_mis && !ALLOW_MISALIGNED);
    w_last = r_i + 3'd1 == r_beats;
    w_asm = r_asm;
    w_asm[{r_i[1:0], 3'b000} +: 8] = dm_dataout[7:0];
    w_ext = r_memop[1:0] == 2'b01 ? {{16{w_asm[15] & ~r_memop[2]}}, w_asm[15:0]} : w_asm;
    w_act = r_state == ISSUE || r_state == CAPTURE;
    dm_addr = w_act ? r_addr + {29'b0, r_i} : 32'b0;
    dm_datain = !w_act ? 32'b0 : r_mis ? {24'b0, r_wdata[{r_i[1:0], 3'b000} +: 8]} : r_wdata;
    dm_memop = !w_act ? 3'b010 : r_mis ? (r_we ? 3'b000 : 3'b100) : r_memop;
    dm_we = r_state == ISSUE && r_we;
    bus.req_ready = r_state == IDLE;
    bus.resp_valid = r_state == RESP;
    bus.resp_rdata = r_rdata;
    bus.resp_err = r_err;
  end
  // sequencer FSM; response data/error are loaded on the edge that enters RESP and held until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr <= 32'b0;
      r_memop <= 3'b010;
      r_we <= 1'b0;
      r_wdata <= 32'b0;
      r_mis <= 1'b0;
      r_i <= 3'd0;
      r_beats <= 3'd1;
      r_asm <= 32'b0;
      r_rdata <= 32'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_addr <= bus.req_addr;
          r_memop <= bus.req_memop;
          r_we <= bus.req_we;
          r_wdata <= bus.req_wdata;
          r_mis <= w_mis;
          r_beats <= w_mis ? w_n : 3'd1;
          r_i <= 3'd0;
          r_state <= w_err ? RESP : ISSUE;
          if (w_err) begin
            r_rdata <= 32'b0;
            r_err <= 1'b1;
          end
        end
        ISSUE: if (r_we) begin
          r_i <= r_i + 3'd1;
          if (w_last) begin
            r_state <= RESP;
            r_rdata <= 32'b0;
            r_err <= 1'b0;
          end
        end else begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_asm <= w_asm;
          r_i <= r_i + 3'd1;
          r_state <= w_last ? RESP : ISSUE;
          if (w_last) begin
            r_rdata <= r_mis ? w_ext : dm_dataout;
            r_err <= 1'b0;
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: scoreboard bench for lsu_seq against a byte-addressed memory model
module tb_lsu_seq;
  typedef struct {string n; logic [31:0] d; logic e; int c;} exp_t;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [2:0] op;} beat_t;
  localparam logic [63:0] PRE = 64'h8877665544332211;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  exp_t sb[$];
  beat_t beats[$];
  logic we1_seen = 1'b0;
  logic [7:0] mem [0:511];
  logic [31:0] dm_addr0, dm_datain0, dm_dataout0, dm_addr1, dm_datain1;
  logic [2:0] dm_memop0, dm_memop1;
  logic dm_we0, dm_we1;
  lsu_seq_if b0();
  lsu_seq_if b1();
  lsu_seq #(.ALLOW_MISALIGNED(1'b1)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .dm_addr(dm_addr0), .dm_datain(dm_datain0),
    .dm_memop(dm_memop0), .dm_we(dm_we0), .dm_dataout(dm_dataout0)
  );
  lsu_seq #(.ALLOW_MISALIGNED(1'b0)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .dm_addr(dm_addr1), .dm_datain(dm_datain1),
    .dm_memop(dm_memop1), .dm_we(dm_we1), .dm_dataout(32'h0)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] rd(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] w;
    w = {mem[9'(a + 32'd3)], mem[9'(a + 32'd2)], mem[9'(a + 32'd1)], mem[9'(a)]};
    case (op)
      3'b000: return {{24{w[7]}}, w[7:0]};
      3'b100: return {24'b0, w[7:0]};
      3'b001: return {{16{w[15]}}, w[15:0]};
      3'b101: return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction
  always @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < 512; j++) mem[j] <= 8'h0;
      for (int j = 0; j < 8; j++) mem[256 + j] <= PRE[8*j +: 8];
    end else if (dm_we0) begin
      for (int j = 0; j < 4; j++)
        if (dm_memop0[1:0] == 2'b10 || (dm_memop0[1:0] == 2'b01 && j < 2) || j == 0)
          mem[9'(dm_addr0 + 32'(j))] <= dm_datain0[8*j +: 8];
    end
    dm_dataout0 <= rd(dm_addr0, dm_memop0);
  end
  always @(negedge clk) begin
    exp_t e;
    if (dm_we0) beats.push_back('{dm_addr0, dm_datain0, dm_memop0});
    if (dm_we1) we1_seen = 1'b1;
    if (b0.resp_valid) begin
      if (sb.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk({e.n, "_lat"}, 32'(cyc), 32'(e.c));
        chk({e.n, "_rdata"}, b0.resp_rdata, e.d);
        chk({e.n, "_err"}, 32'(b0.resp_err), 32'(e.e));
      end
    end
  end
  task automatic send(input string n, input logic [31:0] a, input logic [2:0] op, input logic we,
                      input logic [31:0] wd, input logic [31:0] ed, input logic ee, input int lat,
                      input bit cf, input logic [31:0] fa, input logic [2:0] fop);
    int t;
    @(negedge clk);
    beats.delete();
    b0.req_valid = 1'b1;
    b0.req_addr = a;
    b0.req_memop = op;
    b0.req_we = we;
    b0.req_wdata = wd;
    sb.push_back('{n, ed, ee, cyc + lat});
    @(posedge clk);
    #1 b0.req_valid = 1'b0;
    @(negedge clk);
    if (cf) begin
      chk({n, "_dm_addr"}, dm_addr0, fa);
      chk({n, "_dm_memop"}, 32'(dm_memop0), 32'(fop));
    end
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk({n, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] sd;
    b0.req_valid = 1'b0; b0.req_addr = '0; b0.req_memop = '0; b0.req_we = 1'b0; b0.req_wdata = '0;
    b1.req_valid = 1'b0; b1.req_addr = '0; b1.req_memop = '0; b1.req_we = 1'b0; b1.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    load = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(b0.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
    chk("rst_rdata", b0.resp_rdata, 32'd0);
    chk("rst_err", 32'(b0.resp_err), 32'd0);
    chk("rst_dm_we", 32'(dm_we0), 32'd0);
    chk("rst_dm_addr", dm_addr0, 32'd0);
    chk("rst_dm_datain", dm_datain0, 32'd0);
    chk("rst_dm_memop", 32'(dm_memop0), 32'd2);
    send("lw100", 32'h100, 3'b010, 1'b0, 32'h0, 32'h44332211, 1'b0, 3, 1'b1, 32'h100, 3'b010);
    send("lh106", 32'h106, 3'b001, 1'b0, 32'h0, 32'hFFFF8877, 1'b0, 3, 1'b1, 32'h106, 3'b001);
    send("lb107", 32'h107, 3'b000, 1'b0, 32'h0, 32'hFFFFFF88, 1'b0, 3, 1'b1, 32'h107, 3'b000);
    send("lbu107", 32'h107, 3'b100, 1'b0, 32'h0, 32'h00000088, 1'b0, 3, 1'b1, 32'h107, 3'b100);
    send("lw101", 32'h101, 3'b010, 1'b0, 32'h0, 32'h55443322, 1'b0, 9, 1'b1, 32'h101, 3'b100);
    send("lh103", 32'h103, 3'b001, 1'b0, 32'h0, 32'h00005544, 1'b0, 5, 1'b1, 32'h103, 3'b100);
    sd = 32'hAABBCCDD;
    send("sw102", 32'h102, 3'b010, 1'b1, sd, 32'h0, 1'b0, 5, 1'b1, 32'h102, 3'b000);
    chk("sw102_nbeats", 32'(beats.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < beats.size()) begin
        chk("sw102_beat_addr", beats[i].a, 32'h102 + 32'(i));
        chk("sw102_beat_data", beats[i].d, {24'b0, sd[8*i +: 8]});
        chk("sw102_beat_op", 32'(beats[i].op), 32'd0);
      end
    send("lw100b", 32'h100, 3'b010, 1'b0, 32'h0, 32'hCCDD2211, 1'b0, 3, 1'b1, 32'h100, 3'b010);
    send("lw104b", 32'h104, 3'b010, 1'b0, 32'h0, 32'h8877AABB, 1'b0, 3, 1'b1, 32'h104, 3'b010);
    send("lh103b", 32'h103, 3'b001, 1'b0, 32'h0, 32'hFFFFBBCC, 1'b0, 5, 1'b1, 32'h103, 3'b100);
    send("lhu103b", 32'h103, 3'b101, 1'b0, 32'h0, 32'h0000BBCC, 1'b0, 5, 1'b1, 32'h103, 3'b100);
    send("sh108", 32'h108, 3'b001, 1'b1, 32'hDEAD1234, 32'h0, 1'b0, 2, 1'b1, 32'h108, 3'b001);
    chk("sh108_nbeats", 32'(beats.size()), 32'd1);
    if (beats.size() > 0) chk("sh108_beat_data", beats[0].d, 32'hDEAD1234);
    send("lhu108", 32'h108, 3'b101, 1'b0, 32'h0, 32'h00001234, 1'b0, 3, 1'b1, 32'h108, 3'b101);
    send("err011", 32'h100, 3'b011, 1'b0, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 3'b000);
    chk("err011_no_we", 32'(beats.size()), 32'd0);
    send("err101we", 32'h104, 3'b101, 1'b1, 32'h5A5A, 32'h0, 1'b1, 1, 1'b0, 32'h0, 3'b000);
    chk("err101we_no_we", 32'(beats.size()), 32'd0);
    send("err110", 32'h100, 3'b110, 1'b0, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 3'b000);
    @(negedge clk);
    beats.delete();
    b0.req_valid = 1'b1; b0.req_addr = 32'h102; b0.req_memop = 3'b010; b0.req_we = 1'b1;
    b0.req_wdata = 32'h11223344;
    @(posedge clk);
    #1 b0.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_dm_we", 32'(dm_we0), 32'd0);
    chk("rstmid_ready", 32'(b0.req_ready), 32'd1);
    chk("rstmid_resp_valid", 32'(b0.resp_valid), 32'd0);
    chk("rstmid_rdata", b0.resp_rdata, 32'd0);
    chk("rstmid_nbeats", 32'(beats.size()), 32'd2);
    repeat (3) @(negedge clk);
    send("lw100c", 32'h100, 3'b010, 1'b0, 32'h0, 32'h33442211, 1'b0, 3, 1'b1, 32'h100, 3'b010);
    send("lw104c", 32'h104, 3'b010, 1'b0, 32'h0, 32'h8877AABB, 1'b0, 3, 1'b1, 32'h104, 3'b010);
    @(negedge clk);
    we1_seen = 1'b0;
    b1.req_valid = 1'b1; b1.req_addr = 32'h101; b1.req_memop = 3'b010; b1.req_we = 1'b0;
    @(negedge clk);
    chk("nomis_resp_valid", 32'(b1.resp_valid), 32'd1);
    chk("nomis_err", 32'(b1.resp_err), 32'd1);
    chk("nomis_rdata", b1.resp_rdata, 32'd0);
    chk("nomis_ready_busy", 32'(b1.req_ready), 32'd0);
    b1.req_addr = 32'h103; b1.req_memop = 3'b001;
    @(negedge clk);
    chk("nomis_ready_next", 32'(b1.req_ready), 32'd1);
    chk("nomis_idle_valid", 32'(b1.resp_valid), 32'd0);
    @(negedge clk);
    chk("nomis2_resp_valid", 32'(b1.resp_valid), 32'd1);
    chk("nomis2_err", 32'(b1.resp_err), 32'd1);
    b1.req_valid = 1'b0;
    @(negedge clk);
    chk("nomis_no_we", 32'(we1_seen), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
